// File: rtl/mau_pkg.sv
// Shared AHB encodings, FSM state type and latched request attributes
// for the memory access unit.
package mau_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

  localparam logic [1:0] HRESP_OKAY  = 2'b00;
  localparam logic [1:0] HRESP_ERROR = 2'b01;
  localparam logic [1:0] HRESP_RETRY = 2'b10;
  localparam logic [1:0] HRESP_SPLIT = 2'b11;

  localparam logic [2:0] HSIZE_BYTE = 3'b000;
  localparam logic [2:0] HSIZE_HALF = 3'b001;
  localparam logic [2:0] HSIZE_WORD = 3'b010;

  // Core-side access size encoding
  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [1:0] {IDLE, REQ, ADDR, DATA} mau_state_t;

  typedef struct packed {
    logic       write;
    logic [1:0] size;
    logic       uns;
  } mau_attr_t;

  // Conflicting pulses, illegal size or a misaligned half/word never reach the bus.
  function automatic logic bad_req(input logic ld, input logic st,
                                   input logic [1:0] sz, input logic [1:0] lo);
    logic bad;
    case (sz)
      SZ_BYTE: bad = 1'b0;
      SZ_HALF: bad = lo[0];
      SZ_WORD: bad = (lo != 2'b00);
      default: bad = 1'b1;
    endcase
    return bad | (ld & st);
  endfunction

  function automatic logic [2:0] to_hsize(input logic [1:0] sz);
    case (sz)
      SZ_BYTE: return HSIZE_BYTE;
      SZ_HALF: return HSIZE_HALF;
      default: return HSIZE_WORD;
    endcase
  endfunction

endpackage

// File: rtl/mau_lane.sv
// Byte-lane steering: replicates store data across lanes and extracts,
// then sign/zero-extends, the addressed lane of a load.
module mau_lane
  import mau_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  off,
  input  logic        unsigned_ld,
  input  logic [31:0] wdata,
  input  logic [31:0] hrdata,
  output logic [31:0] hwdata,
  output logic [31:0] rdata
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    hwdata = wdata;
    case (size)
      SZ_BYTE: hwdata = {4{wdata[7:0]}};
      SZ_HALF: hwdata = {2{wdata[15:0]}};
      default: hwdata = wdata;
    endcase
  end

  always_comb begin
    byte_sel = hrdata[7:0];
    case (off)
      2'd1:    byte_sel = hrdata[15:8];
      2'd2:    byte_sel = hrdata[23:16];
      2'd3:    byte_sel = hrdata[31:24];
      default: byte_sel = hrdata[7:0];
    endcase
    half_sel = off[1] ? hrdata[31:16] : hrdata[15:0];
  end

  always_comb begin
    rdata = hrdata;
    case (size)
      SZ_BYTE: rdata = {{24{byte_sel[7] & ~unsigned_ld}}, byte_sel};
      SZ_HALF: rdata = {{16{half_sel[15] & ~unsigned_ld}}, half_sel};
      default: rdata = hrdata;
    endcase
  end

endmodule

// File: rtl/mau_ahb.sv
// Memory access unit: turns single core load/store pulses into single
// AHB transfers with arbitration, retry handling and a bus timeout.
module mau_ahb
  import mau_pkg::*;
#(
  parameter int ADDR_W    = 32,
  parameter int TIMEOUT   = 16,
  parameter int MAX_RETRY = 4
) (
  input  logic              HCLK,
  input  logic              HRESETn,
  output logic [ADDR_W-1:0] HADDR,
  output logic [1:0]        HTRANS,
  output logic              HWRITE,
  output logic [2:0]        HSIZE,
  output logic [2:0]        HBURST,
  output logic [31:0]       HWDATA,
  input  logic [31:0]       HRDATA,
  output logic              HBUSREQ,
  output logic              HLOCK,
  input  logic              HGRANT,
  input  logic              HREADY,
  input  logic [1:0]        HRESP,
  input  logic              req_load,
  input  logic              req_store,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  input  logic [1:0]        size,
  input  logic              unsigned_ld,
  output logic [31:0]       rdata,
  output logic              ready,
  output logic              err,
  output logic              busy
);

  localparam int TW = $clog2(TIMEOUT + 2);
  localparam int RW = $clog2(MAX_RETRY + 2);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT > 0 ? TIMEOUT - 1 : 0);
  localparam logic [RW-1:0] RTY_LAST = RW'(MAX_RETRY > 0 ? MAX_RETRY - 1 : 0);

  mau_state_t        state;
  mau_attr_t         attr;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic [TW-1:0]     tmo_cnt;
  logic [RW-1:0]     retry_cnt;
  logic              tmo_hit;
  logic [31:0]       lane_hwdata;
  logic [31:0]       lane_rdata;

  assign HBURST  = 3'b000;
  assign HLOCK   = 1'b0;
  assign tmo_hit = (TIMEOUT != 0) && (tmo_cnt == TMO_LAST);

  mau_lane u_lane (
    .size        (attr.size),
    .off         (addr_q[1:0]),
    .unsigned_ld (attr.uns),
    .wdata       (wdata_q),
    .hrdata      (HRDATA),
    .hwdata      (lane_hwdata),
    .rdata       (lane_rdata)
  );

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state     <= IDLE;
      attr      <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      tmo_cnt   <= '0;
      retry_cnt <= '0;
      HADDR     <= '0;
      HTRANS    <= HTRANS_IDLE;
      HWRITE    <= 1'b0;
      HSIZE     <= '0;
      HWDATA    <= '0;
      HBUSREQ   <= 1'b0;
      rdata     <= '0;
      ready     <= 1'b0;
      err       <= 1'b0;
      busy      <= 1'b0;
    end else begin
      ready <= 1'b0;
      err   <= 1'b0;
      // busy covers the ready/err cycle itself, then drops unless a new access is accepted
      if (ready || err) busy <= 1'b0;

      case (state)
        IDLE: begin
          if (req_load || req_store) begin
            addr_q     <= addr;
            wdata_q    <= wdata;
            attr.write <= req_store;
            attr.size  <= size;
            attr.uns   <= unsigned_ld;
            busy       <= 1'b1;
            tmo_cnt    <= '0;
            retry_cnt  <= '0;
            if (bad_req(req_load, req_store, size, addr[1:0])) begin
              err <= 1'b1;
            end else begin
              state   <= REQ;
              HBUSREQ <= 1'b1;
            end
          end
        end

        REQ: begin
          if (HGRANT && HREADY) begin
            state   <= ADDR;
            tmo_cnt <= '0;
            HTRANS  <= HTRANS_NONSEQ;
            HADDR   <= addr_q;
            HWRITE  <= attr.write;
            HSIZE   <= to_hsize(attr.size);
          end else if (tmo_hit) begin
            state   <= IDLE;
            tmo_cnt <= '0;
            HBUSREQ <= 1'b0;
            err     <= 1'b1;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end

        ADDR: begin
          if (HREADY) begin
            state   <= DATA;
            tmo_cnt <= '0;
            HTRANS  <= HTRANS_IDLE;
            HWDATA  <= lane_hwdata;
          end
        end

        DATA: begin
          if (HREADY) begin
            tmo_cnt <= '0;
            if (HRESP == HRESP_OKAY) begin
              state   <= IDLE;
              HBUSREQ <= 1'b0;
              ready   <= 1'b1;
              if (!attr.write) rdata <= lane_rdata;
            end else if (HRESP == HRESP_ERROR || retry_cnt == RTY_LAST) begin
              state   <= IDLE;
              HBUSREQ <= 1'b0;
              err     <= 1'b1;
            end else begin
              // RETRY/SPLIT: re-arbitrate and replay the same transfer
              retry_cnt <= retry_cnt + 1'b1;
              state     <= REQ;
            end
          end else if (tmo_hit) begin
            state   <= IDLE;
            tmo_cnt <= '0;
            HBUSREQ <= 1'b0;
            err     <= 1'b1;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
